ordenador9_stream_io: RTL and testbench

ORDENADOR9_STREAM_IO -- requirements
Module: ordenador9_stream_io

---
 rtl/ordenador9_stream_io_pkg.sv | 14 +
 rtl/ordenador9_stream_io.sv | 124 ++++++++++++
 tb/tb_ordenador9_stream_io.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ordenador9_stream_io_pkg.sv
// Shared definitions for the nine-word streaming front end of the sorter:
// controller state encoding and the fixed frame size.
package ordenador9_stream_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SORT  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam int N = 9;

endpackage

// File: rtl/ordenador9_stream_io.sv
// Streaming wrapper around an external nine-input sorter: collects nine words,
// holds them on sort_in while the sorter settles, then replays the sorted frame.
module ordenador9_stream_io #(
  parameter int W        = 4,
  parameter int N        = 9,
  parameter int SORT_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [N*W-1:0] sort_in,
  input  logic [N*W-1:0] sort_out,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic           sort_en,
  output logic           frame_done
);
  import ordenador9_stream_io_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(N - 1);
  localparam logic [3:0] LAT      = 4'(SORT_LAT);

  state_t       state, state_nx;
  logic [3:0]   idx, idx_nx;
  logic [3:0]   wait_cnt, wait_nx;
  logic         capture;
  logic [W-1:0] in_reg  [N];
  logic [W-1:0] out_reg [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      wait_cnt <= wait_nx;
    end
  end

  // SORT holds for SORT_LAT settle cycles plus the capture cycle.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wait_nx  = wait_cnt;
    capture  = 1'b0;
    case (state)
      IDLE: state_nx = LOAD;
      LOAD: begin
        if (in_valid) begin
          if (idx == LAST_IDX) begin
            idx_nx   = 4'd0;
            wait_nx  = 4'd0;
            state_nx = SORT;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      SORT: begin
        if (wait_cnt == LAT) begin
          capture  = 1'b1;
          wait_nx  = 4'd0;
          state_nx = DRAIN;
        end else begin
          wait_nx = wait_cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            idx_nx   = 4'd0;
            state_nx = LOAD;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
        wait_nx  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        in_reg[i]  <= '0;
        out_reg[i] <= '0;
      end
    end else begin
      if (state == LOAD && in_valid) begin
        in_reg[idx] <= in_data;
      end
      if (capture) begin
        for (int i = 0; i < N; i++) begin
          out_reg[i] <= sort_out[i*W +: W];
        end
      end
    end
  end

  always_comb begin
    sort_in = '0;
    for (int i = 0; i < N; i++) begin
      sort_in[i*W +: W] = in_reg[i];
    end
  end

  assign in_ready   = (state == LOAD);
  assign sort_en    = (state == SORT);
  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? out_reg[idx] : '0;
  assign out_last   = out_valid && (idx == LAST_IDX);
  assign frame_done = out_valid && out_ready && (idx == LAST_IDX);

endmodule

// File: tb/tb_ordenador9_stream_io.sv
// Directed bench for ordenador9_stream_io with a behavioural sorter model;
// a second instance with SORT_LAT=3 shares the input stream for latency checks.
module tb_ordenador9_stream_io;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, out_ready3;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, out_last, sort_en, frame_done;
  logic [3:0]  out_data;
  logic [35:0] sort_in, sort_out;
  logic        in_ready3, out_valid3, out_last3, sort_en3, frame_done3;
  logic [3:0]  out_data3;
  logic [35:0] sort_in3, sort_out3;

  int checks   = 0;
  int failures = 0;

  logic [3:0] frame_a[9], sorted_a[9], frame_b[9], sorted_b[9], frame_c[9], frame_8[9];

  always #5 clk = ~clk;

  function automatic logic [35:0] sort9(input logic [35:0] v);
    logic [3:0]  a[9];
    logic [3:0]  t;
    logic [35:0] r;
    for (int i = 0; i < 9; i++) a[i] = v[i*4 +: 4];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 9; i++) r[i*4 +: 4] = a[i];
    return r;
  endfunction

  assign sort_out  = sort9(sort_in);
  assign sort_out3 = sort9(sort_in3);

  ordenador9_stream_io #(.W(4), .N(9), .SORT_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sort_in(sort_in), .sort_out(sort_out), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .sort_en(sort_en), .frame_done(frame_done)
  );

  ordenador9_stream_io #(.W(4), .N(9), .SORT_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
    .sort_in(sort_in3), .sort_out(sort_out3), .out_valid(out_valid3), .out_data(out_data3),
    .out_last(out_last3), .out_ready(out_ready3), .sort_en(sort_en3), .frame_done(frame_done3)
  );

  task automatic push_word(input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [3:0] w[9], input int gap);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      push_word(w[i]);
    end
  endtask

  task automatic pop_frame(input logic [3:0] exp[9], input int stall_at, input int stall_len,
                           input bit junk);
    int got = 0, cyc = 0, stalled = 0;
    while (got < 9 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 4'hA;
      end
      if (out_valid && got == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        #1;
        checks++;
        if (out_data !== exp[got] || out_valid !== 1'b1 || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold data=%0d valid=%b required data=%0d valid=1",
                   out_data, out_valid, exp[got]);
        end
      end else begin
        out_ready = 1'b1;
        #1;
        if (out_valid) begin
          checks++;
          if (out_data !== exp[got]) begin
            failures++;
            $display("FAIL out_data[%0d] got=%0d required=%0d", got, out_data, exp[got]);
          end
          checks++;
          if (out_last !== (got == 8)) begin
            failures++;
            $display("FAIL out_last[%0d] got=%b required=%b", got, out_last, (got == 8));
          end
          checks++;
          if (frame_done !== (got == 8)) begin
            failures++;
            $display("FAIL frame_done[%0d] got=%b required=%b", got, frame_done, (got == 8));
          end
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_drain[%0d] got=%b required=0", got, in_ready);
          end
          got++;
        end
      end
    end
    checks++;
    if (got < 9) begin
      failures++;
      $display("FAIL pop_timeout words=%0d required=9", got);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_sort_in(input logic [35:0] exp, input string name);
    checks++;
    if (sort_in !== exp || sort_en !== 1'b1) begin
      failures++;
      $display("FAIL %s sort_in=%h sort_en=%b required %h/1", name, sort_in, sort_en, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, sort_en, frame_done} !== 5'b0 || out_data !== 4'd0
        || sort_in !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs flags=%b data=%0d sort_in=%h required all zero",
               {in_ready, out_valid, out_last, sort_en, frame_done}, out_data, sort_in);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    push_frame(frame_a, 0);
    check_sort_in(36'h244F01739, "basic_sort_in");
    pop_frame(sorted_a, -1, 0, 1'b1);
  endtask

  task automatic test_gaps();
    push_frame(frame_a, 1);
    check_sort_in(36'h244F01739, "gap_sort_in");
    pop_frame(sorted_a, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    push_frame(frame_a, 0);
    pop_frame(sorted_a, 4, 3, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_word(frame_a[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (sort_in !== 36'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset sort_in=%h in_ready=%b out_valid=%b required 0/0/0",
               sort_in, in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_frame(frame_8, 0);
    check_sort_in(36'h888888888, "eights_sort_in");
    pop_frame(frame_8, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    push_frame(frame_b, 0);
    check_sort_in(36'h789ABCDEF, "b2b_sort_in");
    pop_frame(sorted_b, -1, 0, 1'b0);
    push_frame(frame_c, 0);
    check_sort_in(36'h876543210, "b2b_second_sort_in");
    pop_frame(frame_c, -1, 0, 1'b0);
  endtask

  task automatic test_latency();
    out_ready3 = 1'b0;
    apply_reset();
    push_frame(frame_a, 0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== (c >= 2) || out_valid3 !== (c >= 4)) begin
        failures++;
        $display("FAIL latency_cycle%0d valid=%b valid3=%b required %b/%b",
                 c, out_valid, out_valid3, (c >= 2), (c >= 4));
      end
      if (c == 3) begin
        checks++;
        if (sort_en3 !== 1'b1 || in_ready3 !== 1'b0) begin
          failures++;
          $display("FAIL lat3_sort_en got=%b in_ready3=%b required 1/0", sort_en3, in_ready3);
        end
      end
    end
    checks++;
    if (out_data3 !== 4'd0 || out_last3 !== 1'b0 || frame_done3 !== 1'b0) begin
      failures++;
      $display("FAIL lat3_first_word got=%0d last=%b required 0/0", out_data3, out_last3);
    end
    pop_frame(sorted_a, -1, 0, 1'b0);
  endtask

  initial begin
    frame_a  = '{4'd9, 4'd3, 4'd7, 4'd1, 4'd0, 4'd15, 4'd4, 4'd4, 4'd2};
    sorted_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd7, 4'd9, 4'd15};
    frame_b  = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7};
    sorted_b = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    frame_c  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    frame_8  = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'd0;
    out_ready  = 1'b0;
    out_ready3 = 1'b1;

    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_latency();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
